// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - per-layer load sequencer driving the neuron/weight address generator.
// Optional LAYER_SEQ_PERF_EN adds a 32-bit perf_cycles busy-cycle counter output.
module layer_sequencer #(
    parameter int IP_DATA_BUS_WIDTH         = 16,
    parameter int NEURON_ADDRESS_BUS_WIDTH  = 8,
    parameter int WEIGHTS_ADDRESS_BUS_WIDTH = 16,
    parameter int MAX_LAYERS                = 8,
    parameter int LAYER_IDX_WIDTH           = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [LAYER_IDX_WIDTH:0]             num_layers,
    input  logic [NEURON_ADDRESS_BUS_WIDTH-1:0]  input_base_addr,
    input  logic [WEIGHTS_ADDRESS_BUS_WIDTH-1:0] weight_base_addr,
    output logic [LAYER_IDX_WIDTH-1:0]           size_rd_addr,
    input  logic [IP_DATA_BUS_WIDTH-1:0]         size_rd_data,
    output logic                                 ag_read,
    output logic [IP_DATA_BUS_WIDTH-1:0]         ag_Nk,
    output logic [WEIGHTS_ADDRESS_BUS_WIDTH-1:0] ag_weight_base,
    output logic [NEURON_ADDRESS_BUS_WIDTH-1:0]  ag_read_neuro_base,
    output logic [NEURON_ADDRESS_BUS_WIDTH-1:0]  ag_write_neuro_base,
    input  logic                                 ag_finished,
    output logic                                 run_active,
    output logic [LAYER_IDX_WIDTH-1:0]           layer_idx,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error
`ifdef LAYER_SEQ_PERF_EN
    ,
    output logic [31:0]                          perf_cycles
`endif
);
    localparam int IPW = IP_DATA_BUS_WIDTH;
    localparam int NAW = NEURON_ADDRESS_BUS_WIDTH;
    localparam int WAW = WEIGHTS_ADDRESS_BUS_WIDTH;
    localparam int LIW = LAYER_IDX_WIDTH;
    localparam logic [LIW:0] MAX_NL = (LIW+1)'(MAX_LAYERS);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPTURE, S_LOAD, S_RUN, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LIW-1:0]   r_idx;
    logic [LIW:0]     r_num_layers;
    logic             r_cfg_err;
    logic             r_error;
    logic [IPW-1:0]   r_cur_size;
    logic [IPW-1:0]   r_prev_size;
    logic [NAW-1:0]   r_rd_base;
    logic [NAW-1:0]   r_wr_base;
    logic [WAW-1:0]   r_w_base;
    logic             w_last;
    logic             w_bad_count;
    logic [WAW-1:0]   w_prod;

    assign w_last      = ({1'b0, r_idx} == (r_num_layers - 1'b1));
    assign w_bad_count = (num_layers < (LIW+1)'(2)) || (num_layers > MAX_NL);
    // Truncating the operands first gives the same low WAW bits as the full product.
    assign w_prod      = WAW'(r_prev_size) * WAW'(r_cur_size);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_FETCH;
            S_FETCH:   w_next = r_cfg_err ? S_DONE : S_CAPTURE;
            S_CAPTURE: w_next = (size_rd_data == '0) ? S_DONE : S_LOAD;
            S_LOAD:    w_next = (r_idx == '0) ? S_FETCH : S_RUN;
            S_RUN:     if (ag_finished) w_next = w_last ? S_DONE : S_FETCH;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx        <= '0;
            r_num_layers <= '0;
            r_cfg_err    <= 1'b0;
            r_error      <= 1'b0;
            r_cur_size   <= '0;
            r_prev_size  <= '0;
            r_rd_base    <= '0;
            r_wr_base    <= '0;
            r_w_base     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_error      <= 1'b0;
                    r_idx        <= '0;
                    r_num_layers <= num_layers;
                    r_cfg_err    <= w_bad_count;
                    r_rd_base    <= input_base_addr;
                    r_w_base     <= weight_base_addr;
                end
                S_FETCH: if (r_cfg_err) r_error <= 1'b1;
                S_CAPTURE: begin
                    r_cur_size <= size_rd_data;
                    if (size_rd_data == '0)
                        r_error <= 1'b1;
                    else if (r_idx == '0)
                        r_wr_base <= r_rd_base + NAW'(size_rd_data);
                end
                S_LOAD: if (r_idx == '0) begin
                    r_prev_size <= r_cur_size;
                    r_idx       <= r_idx + 1'b1;
                end
                S_RUN: if (ag_finished) begin
                    r_rd_base   <= r_wr_base;
                    r_wr_base   <= r_wr_base + NAW'(r_cur_size);
                    r_w_base    <= r_w_base + w_prod;
                    r_prev_size <= r_cur_size;
                    if (!w_last) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] r_perf;
    always_ff @(posedge clk) begin
        if (reset)                          r_perf <= '0;
        else if (r_state == S_IDLE && start) r_perf <= '0;
        else if (r_state != S_IDLE)          r_perf <= r_perf + 32'd1;
    end
    assign perf_cycles = r_perf;
`endif

    always_comb begin
        size_rd_addr        = '0;
        ag_read             = 1'b0;
        ag_Nk               = '0;
        ag_weight_base      = '0;
        ag_read_neuro_base  = '0;
        ag_write_neuro_base = '0;
        run_active          = (r_state == S_RUN);
        busy                = (r_state != S_IDLE);
        done                = (r_state == S_DONE);
        error               = r_error;
        layer_idx           = (r_state != S_IDLE) ? r_idx : '0;
        if (r_state == S_FETCH) size_rd_addr = r_idx;
        if (r_state == S_LOAD) begin
            ag_read = 1'b1;
            ag_Nk   = r_cur_size;
            // The priming load only hands the input-layer size to the generator.
            if (r_idx != '0) begin
                ag_weight_base      = r_w_base;
                ag_read_neuro_base  = r_rd_base;
                ag_write_neuro_base = r_wr_base;
            end
        end
    end
endmodule
